// File: rtl/aes_pkg.sv
// Shared AES definitions for the forward and inverse key schedules.
// Contents:
//   AES_KEY_W / AES_NR : AES-128 key width and round count
//   ks_state_e         : key-schedule FSM states (IDLE, EXPAND, DONE)
//   sbox(b)            : forward S-box lookup, one byte
//   rcon(r)            : round constant byte for rounds 1..10 (0 otherwise)
package aes_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_NR    = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_e;

  // Forward S-box, entry 0 in the most significant byte, one row of 16 per line.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One backwards step of the AES-128 key expansion (combinational).
// Ports:
//   key_in  [127:0] : round key i, {w0,w1,w2,w3}, w0 in [127:96]
//   round   [3:0]   : i, selects the round constant (1..10)
//   key_out [127:0] : round key i-1
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic [3:0]           round,
  output logic [AES_KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot_w, sub_w;

  assign {w0, w1, w2, w3} = key_in;

  // Words 1..3 of the previous key fall out of adjacent XORs of this key.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // Word 0 needs the recovered previous word 3 pushed through RotWord/SubWord.
  assign rot_w = {p3[23:0], p3[31:24]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
  assign p0    = w0 ^ sub_w ^ {rcon(round), 24'h0};

  assign key_out = {p0, p1, p2, p3};

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule. Loads the final round key, regenerates round
// keys NR-1 down to 0 at one round per clock, stores all NR+1 keys and serves
// them by index through a registered read port.
// Ports:
//   clk              : rising-edge clock
//   rest             : asynchronous active-low reset
//   start            : one-cycle pulse, accepted in IDLE or DONE
//   last_key [127:0] : final round key, w0 in [127:96]
//   rd_round [3:0]   : round key index to read
//   rd_key   [127:0] : registered key for rd_round, 0 when not valid
//   busy             : expansion in progress
//   done             : all keys stored, held until next start or reset
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] last_key,
  input  logic [3:0]           rd_round,
  output logic [AES_KEY_W-1:0] rd_key,
  output logic                 busy,
  output logic                 done
);

  localparam int RND_W = 4;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

  ks_state_e             state_q, state_d;
  logic [RND_W-1:0]      rnd_q, rnd_d;
  logic [AES_KEY_W-1:0]  cur_key_q, cur_key_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [AES_KEY_W-1:0]  rd_key_q, rd_key_d;

  logic [AES_KEY_W-1:0]  keys_q [NR+1];

  logic                  wr_en;
  logic [RND_W-1:0]      wr_idx;
  logic [AES_KEY_W-1:0]  wr_data;
  logic [AES_KEY_W-1:0]  step_key;

  aes_inv_key_step u_step (
    .key_in  (cur_key_q),
    .round   (rnd_q),
    .key_out (step_key)
  );

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    cur_key_d = cur_key_q;
    busy_d    = busy_q;
    done_d    = done_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = step_key;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_EXPAND;
          cur_key_d = last_key;
          rnd_d     = LAST_RND;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          wr_en     = 1'b1;
          wr_idx    = LAST_RND;
          wr_data   = last_key;
        end
      end
      ST_EXPAND: begin
        // start is deliberately not looked at here: a running expansion
        // always completes.
        cur_key_d = step_key;
        rnd_d     = rnd_q - 4'd1;
        wr_en     = 1'b1;
        wr_idx    = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads are gated by done, so a partial or aborted store is never exposed.
  always_comb begin
    rd_key_d = '0;
    if (done_q && (rd_round <= LAST_RND)) begin
      rd_key_d = keys_q[rd_round];
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q   <= ST_IDLE;
      rnd_q     <= '0;
      cur_key_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_key_q  <= '0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      cur_key_q <= cur_key_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_key_q  <= rd_key_d;
    end
  end

  // Key store carries no reset; its contents only matter once done is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      keys_q[wr_idx] <= wr_data;
    end
  end

  assign rd_key = rd_key_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
